// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the fetch sequencer and its buffer.
// The optional performance counters are enabled with FETCH_CTRL_PERF_EN.
package fetch_ctrl_pkg;

    localparam int XLEN       = 64;
    localparam int FBUF_DEPTH = 4;

    typedef enum logic {
        RUN,
        FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, inst} entries. Flush empties it in one cycle
// and takes priority over a simultaneous push or pop.
module fetch_fifo
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = FBUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  fetch_entry_t             entry_i,
    input  logic                     pop_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC generation, credit-limited I-cache requests, redirect flush.
// Define FETCH_CTRL_PERF_EN to build the stall/drop performance counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              XLEN       = fetch_ctrl_pkg::XLEN,
    parameter int              FBUF_DEPTH = fetch_ctrl_pkg::FBUF_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          redirect_valid_i,
    input  logic [XLEN-1:0]               redirect_pc_i,
    input  logic                          fetch_addr_ready_i,
    output logic                          fetch_addr_valid_o,
    output logic [XLEN-1:0]               fetch_addr_o,
    input  logic                          fetch_data_valid_i,
    input  logic [31:0]                   fetch_data_i,
    output logic                          dec_valid_o,
    output logic [XLEN-1:0]               dec_pc_o,
    output logic [31:0]                   dec_inst_o,
    input  logic                          dec_ready_i,
    output logic [$clog2(FBUF_DEPTH):0]   outstanding_o,
    output logic [31:0]                   perf_stall_cycles_o,
    output logic [31:0]                   perf_dropped_o
);

    localparam int CW = $clog2(FBUF_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   drop_on_redirect;
    logic [CW-1:0]   credit;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty, fifo_full;
    logic            req_fire, push, pop;
    logic [XLEN-1:0] redirect_pc_aligned;
    fetch_entry_t    push_entry, head;

    // Both handshakes complete on a rising edge where valid and ready are high;
    // valid never depends on the matching ready.
    assign credit              = CW'(FBUF_DEPTH) - (fifo_count + out_q);
    assign redirect_pc_aligned = redirect_pc_i & ~XLEN'(3);
    assign drop_on_redirect    = out_q - CW'(fetch_data_valid_i);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid_i)
            state_d = (drop_on_redirect != '0) ? FLUSH : RUN;
        else if (state_q == FLUSH && drop_d == '0)
            state_d = RUN;
    end

    // rstn gates the request so it drops the moment reset asserts.
    always_comb begin
        fetch_addr_valid_o = rstn && (state_q == RUN) && (credit != '0) && !redirect_valid_i;
        req_fire           = fetch_addr_valid_o && fetch_addr_ready_i;
        push               = (state_q == RUN) && fetch_data_valid_i && !redirect_valid_i;
        dec_valid_o        = !fifo_empty && !redirect_valid_i;
        pop                = dec_valid_o && dec_ready_i;
    end

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        drop_d    = drop_q;
        out_d     = out_q + CW'(req_fire) - CW'(fetch_data_valid_i);
        if (redirect_valid_i) begin
            pc_d      = redirect_pc_aligned;
            resp_pc_d = redirect_pc_aligned;
            drop_d    = drop_on_redirect;
        end else begin
            if (req_fire) pc_d = pc_q + XLEN'(4);
            if (push)     resp_pc_d = resp_pc_q + XLEN'(4);
            if (state_q == FLUSH && fetch_data_valid_i && drop_q != '0)
                drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            drop_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
        end
    end

    assign push_entry = '{pc: resp_pc_q, inst: fetch_data_i};

    fetch_fifo #(.DEPTH(FBUF_DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (redirect_valid_i),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign fetch_addr_o  = pc_q;
    assign dec_pc_o      = head.pc;
    assign dec_inst_o    = head.inst;
    assign outstanding_o = out_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] dropped_q, dropped_d;

    always_comb begin
        stall_d   = stall_q;
        dropped_d = dropped_q;
        if (state_q == RUN && credit == '0 && stall_q != '1)
            stall_d = stall_q + 32'd1;
        if (fetch_data_valid_i && (redirect_valid_i || state_q == FLUSH) && dropped_q != '1)
            dropped_d = dropped_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q   <= '0;
            dropped_q <= '0;
        end else begin
            stall_q   <= stall_d;
            dropped_q <= dropped_d;
        end
    end

    assign perf_stall_cycles_o = stall_q;
    assign perf_dropped_o      = dropped_q;
`else
    assign perf_stall_cycles_o = '0;
    assign perf_dropped_o      = '0;
`endif

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (!rstn) !(fetch_data_valid_i && out_q == '0));
    assert property (@(posedge clk) disable iff (!rstn) !(push && fifo_full && !pop));
    assert property (@(posedge clk) disable iff (!rstn) drop_q <= out_q);
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a cache model answers requests one cycle later,
// and a monitor scores request addresses and decode entries against expected queues.
`timescale 1ns/1ps
module tb_fetch_ctrl;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rstn;
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            fetch_addr_ready_i;
    logic            fetch_addr_valid_o;
    logic [XLEN-1:0] fetch_addr_o;
    logic            fetch_data_valid_i;
    logic [31:0]     fetch_data_i;
    logic            dec_valid_o;
    logic [XLEN-1:0] dec_pc_o;
    logic [31:0]     dec_inst_o;
    logic            dec_ready_i;
    logic [2:0]      outstanding_o;
    logic [31:0]     perf_stall_cycles_o;
    logic [31:0]     perf_dropped_o;

    logic            resp_en;
    logic [XLEN-1:0] req_exp_q[$];
    logic [XLEN-1:0] dec_exp_q[$];
    logic [XLEN-1:0] pend_q[$];
    int              n_vec = 0;
    int              n_err = 0;

    fetch_ctrl dut (
        .clk                 (clk),
        .rstn                (rstn),
        .redirect_valid_i    (redirect_valid_i),
        .redirect_pc_i       (redirect_pc_i),
        .fetch_addr_ready_i  (fetch_addr_ready_i),
        .fetch_addr_valid_o  (fetch_addr_valid_o),
        .fetch_addr_o        (fetch_addr_o),
        .fetch_data_valid_i  (fetch_data_valid_i),
        .fetch_data_i        (fetch_data_i),
        .dec_valid_o         (dec_valid_o),
        .dec_pc_o            (dec_pc_o),
        .dec_inst_o          (dec_inst_o),
        .dec_ready_i         (dec_ready_i),
        .outstanding_o       (outstanding_o),
        .perf_stall_cycles_o (perf_stall_cycles_o),
        .perf_dropped_o      (perf_dropped_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] inst_of(input logic [XLEN-1:0] pc);
        return pc[31:0] ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_dropped(input string name, input logic [31:0] exp_when_enabled);
`ifdef FETCH_CTRL_PERF_EN
        check(name, perf_dropped_o, exp_when_enabled);
`else
        check(name, perf_dropped_o, 32'(exp_when_enabled & 32'h0));
`endif
    endtask

    task automatic check_stall(input string name, input logic [31:0] exp_when_enabled);
`ifdef FETCH_CTRL_PERF_EN
        check(name, perf_stall_cycles_o, exp_when_enabled);
`else
        check(name, perf_stall_cycles_o, 32'(exp_when_enabled & 32'h0));
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_reqs(input logic [XLEN-1:0] base, input int n);
        for (int i = 0; i < n; i++) req_exp_q.push_back(base + XLEN'(4 * i));
    endtask

    task automatic push_decs(input logic [XLEN-1:0] base, input int n);
        for (int i = 0; i < n; i++) dec_exp_q.push_back(base + XLEN'(4 * i));
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; returns at the falling edge where reset releases.
    task automatic do_reset();
        rstn             = 1'b0;
        redirect_valid_i = 1'b0;
        #1;
        check("rst_addr_valid", XLEN'(fetch_addr_valid_o), 0);
        check("rst_dec_valid", XLEN'(dec_valid_o), 0);
        check("rst_outstanding", XLEN'(outstanding_o), 0);
        check("rst_perf_stall", XLEN'(perf_stall_cycles_o), 0);
        check("rst_perf_dropped", XLEN'(perf_dropped_o), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic end_test(input string name);
        check({name, "_req_left"}, XLEN'(req_exp_q.size()), 0);
        check({name, "_dec_left"}, XLEN'(dec_exp_q.size()), 0);
        req_exp_q.delete();
        dec_exp_q.delete();
    endtask

    // ---------------- cache model ----------------
    initial begin
        fetch_data_valid_i = 1'b0;
        fetch_data_i       = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rstn) begin
                pend_q.delete();
                fetch_data_valid_i = 1'b0;
            end else if (resp_en && pend_q.size() > 0) begin
                fetch_data_valid_i = 1'b1;
                fetch_data_i       = inst_of(pend_q.pop_front());
            end else begin
                fetch_data_valid_i = 1'b0;
            end
            #1;
            if (rstn && fetch_addr_valid_o && fetch_addr_ready_i)
                pend_q.push_back(fetch_addr_o);
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [XLEN-1:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (rstn && fetch_addr_valid_o && fetch_addr_ready_i) begin
                if (req_exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL req_unexpected: got %0h want none", fetch_addr_o);
                end else begin
                    e = req_exp_q.pop_front();
                    check("req_addr", fetch_addr_o, e);
                end
            end
            if (rstn && dec_valid_o && dec_ready_i) begin
                if (dec_exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL dec_unexpected: got pc %0h want none", dec_pc_o);
                end else begin
                    e = dec_exp_q.pop_front();
                    check("dec_pc", dec_pc_o, e);
                    check("dec_inst", XLEN'(dec_inst_o), XLEN'(inst_of(e)));
                end
            end
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        rstn               = 1'b0;
        redirect_valid_i   = 1'b0;
        redirect_pc_i      = '0;
        fetch_addr_ready_i = 1'b1;
        dec_ready_i        = 1'b0;
        resp_en            = 1'b1;
        @(negedge clk);

        // Streaming: first decode two cycles after first request, then gapless.
        do_reset();
        dec_ready_i = 1'b1;
        push_reqs(0, 10);
        push_decs(0, 8);
        step(1);
        #4 check("lat_c2_dec_valid", XLEN'(dec_valid_o), 0);
        @(negedge clk);
        #4 check("lat_c3_dec_valid", XLEN'(dec_valid_o), 1);
        check("lat_c3_dec_pc", dec_pc_o, 0);
        check("stream_outstanding", XLEN'(outstanding_o), 1);
        step(8);
        end_test("stream");

        // Decode stalled: credit stops at four, then drains in order.
        do_reset();
        dec_ready_i = 1'b0;
        push_reqs(0, 4);
        step(7);
        #4 check("full_addr_valid", XLEN'(fetch_addr_valid_o), 0);
        check("full_dec_valid", XLEN'(dec_valid_o), 1);
        check("full_head_pc", dec_pc_o, 0);
        check("full_outstanding", XLEN'(outstanding_o), 0);
        check_stall("full_stall_cnt", 3);
        @(negedge clk);
        dec_ready_i = 1'b1;
        push_decs(0, 6);
        push_reqs(64'h10, 5);
        step(6);
        end_test("drain");

        // Redirect with three requests in flight.
        do_reset();
        dec_ready_i = 1'b1;
        resp_en     = 1'b0;
        push_reqs(0, 3);
        step(3);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h1003;
        #4 check("redir_outstanding", XLEN'(outstanding_o), 3);
        check("redir_addr_valid", XLEN'(fetch_addr_valid_o), 0);
        @(negedge clk);
        redirect_valid_i = 1'b0;
        resp_en          = 1'b1;
        #4 check("flush_addr_valid", XLEN'(fetch_addr_valid_o), 0);
        push_reqs(64'h1000, 4);
        push_decs(64'h1000, 2);
        step(7);
        check_dropped("redir_dropped", 3);
        end_test("redir");

        // Redirect coinciding with a response and a ready head.
        do_reset();
        dec_ready_i = 1'b1;
        resp_en     = 1'b1;
        push_reqs(0, 2);
        step(2);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h2000;
        #4 check("coll_dec_valid", XLEN'(dec_valid_o), 0);
        check("coll_addr_valid", XLEN'(fetch_addr_valid_o), 0);
        check("coll_outstanding", XLEN'(outstanding_o), 1);
        push_reqs(64'h2000, 4);
        push_decs(64'h2000, 2);
        @(negedge clk);
        redirect_valid_i = 1'b0;
        #4 check("coll_next_valid", XLEN'(fetch_addr_valid_o), 1);
        check("coll_next_addr", fetch_addr_o, 64'h2000);
        check("coll_buf_flushed", XLEN'(dec_valid_o), 0);
        check("coll_outstanding2", XLEN'(outstanding_o), 0);
        step(4);
        check_dropped("coll_dropped", 1);
        end_test("coll");

        // Second redirect while still flushing.
        do_reset();
        dec_ready_i = 1'b1;
        resp_en     = 1'b0;
        push_reqs(0, 3);
        step(3);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h1000;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        resp_en          = 1'b1;
        @(negedge clk);
        resp_en          = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h2000;
        #4 check("reflush_outstanding", XLEN'(outstanding_o), 2);
        @(negedge clk);
        redirect_valid_i = 1'b0;
        resp_en          = 1'b1;
        #4 check("reflush_hold1", XLEN'(fetch_addr_valid_o), 0);
        @(negedge clk);
        #4 check("reflush_hold2", XLEN'(fetch_addr_valid_o), 0);
        push_reqs(64'h2000, 3);
        push_decs(64'h2000, 1);
        @(negedge clk);
        #4 check("reflush_resume", XLEN'(fetch_addr_valid_o), 1);
        check("reflush_addr", fetch_addr_o, 64'h2000);
        step(3);
        check_dropped("reflush_dropped", 3);
        end_test("reflush");

        // Reset pulsed with the buffer half full.
        do_reset();
        dec_ready_i = 1'b0;
        resp_en     = 1'b1;
        push_reqs(0, 3);
        step(3);
        end_test("pre_rst");
        do_reset();
        dec_ready_i = 1'b1;
        push_reqs(0, 4);
        push_decs(0, 2);
        step(4);
        end_test("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
